cnt_bin2bcd: RTL and testbench

- Sequential binary-to-BCD converter that reads the 10-bit value produced by the team's mod-1000 counter.
- Emits three BCD digits (hundreds/tens/ones) for display logic.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.
- Sits between the counter output and the 7-segment/display driver.

---
 rtl/cnt_bin2bcd.sv | 116 +++++++++++
 tb/tb_cnt_bin2bcd.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cnt_bin2bcd.sv
// Sequential double-dabble converter: 10-bit counter value to three BCD digits, one bit per clock.
// Optional out-of-range flag and saturation when BIN2BCD_RANGE_CHK_EN is defined.
module cnt_bin2bcd #(
  parameter int BIN_W  = 10,
  parameter int MAXVAL = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hund,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST_BIT = 4'(BIN_W - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [11:0]      dig_q, dig_d;
  logic [11:0]      res_q, res_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [11:0]      dig_adj, dig_shf;
  logic             accept, last, sat;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign accept = start && (state_q != SHIFT);
  assign last   = (state_q == SHIFT) && (cnt_q == LAST_BIT);

  // Carry out of the hundreds MSB is dropped, so the result is bin mod 1000.
  assign dig_adj = {add3(dig_q[11:8]), add3(dig_q[7:4]), add3(dig_q[3:0])};
  assign dig_shf = {dig_adj[10:0], sr_q[BIN_W-1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      SHIFT: begin
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        dig_d = dig_shf;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          res_d   = sat ? 12'h999 : dig_shf;
          state_d = DONE;
        end
      end
      default: begin
        if (accept) begin
          sr_d    = bin;
          dig_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dig_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIN2BCD_RANGE_CHK_EN
  logic oor_q, err_q;

  // Range is judged on the captured value; err is refreshed on every completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) oor_q <= (32'(bin) > MAXVAL);
      if (last)   err_q <= oor_q;
    end
  end

  assign sat = oor_q;
  assign err = err_q;
`else
  logic unused_maxval;
  assign unused_maxval = ^MAXVAL;
  assign sat = 1'b0;
  assign err = 1'b0;
`endif

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign hund = res_q[11:8];
  assign tens = res_q[7:4];
  assign ones = res_q[3:0];

endmodule

// File: tb/tb_cnt_bin2bcd.sv
// Directed bench for cnt_bin2bcd: latency, handshake, back-to-back, abort and range behaviour.
module tb_cnt_bin2bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] bin = '0;
  logic       busy, done, err;
  logic [3:0] hund, tens, ones;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] prev_res = 12'h000;

  cnt_bin2bcd #(.BIN_W(10), .MAXVAL(999)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .hund(hund), .tens(tens), .ones(ones), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then watch up to 16 cycles for done.
  task automatic run_conv(input string tag, input logic [9:0] b,
                          input logic [11:0] exp, input logic exp_err);
    int done_at = -1;
    int nbusy = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    bin   = ~b;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        done_at = j;
        break;
      end
      if (j == 5) chk({tag, "_hold"}, {hund, tens, ones}, prev_res);
    end
    chk({tag, "_lat"}, done_at, 10);
    chk({tag, "_busy"}, nbusy, 10);
    chk({tag, "_dig"}, {hund, tens, ones}, exp);
    chk({tag, "_err"}, err, exp_err);
    @(negedge clk);
    chk({tag, "_dw"}, done, 1'b0);
    prev_res = exp;
  endtask

  initial begin
    int ndone;
    int gap;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dig", {hund, tens, ones}, 12'h000);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("idle_quiet", ndone, 0);

    run_conv("c0", 10'd0, 12'h000, 1'b0);
    run_conv("c507", 10'd507, 12'h507, 1'b0);
    run_conv("c999", 10'd999, 12'h999, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd123;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int j = 0; j < 26; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 4) begin
        start = 1'b1;
        bin   = 10'd456;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        chk("bp_dig", {hund, tens, ones}, 12'h123);
      end
    end
    chk("bp_ndone", ndone, 1);
    prev_res = 12'h123;

    // Back-to-back: restart in the DONE cycle
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd42;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 16 && !done; j++) @(negedge clk);
    chk("b2b_first", {hund, tens, ones}, 12'h042);
    start = 1'b1;
    bin   = 10'd860;
    @(negedge clk);
    start = 1'b0;
    gap = -1;
    for (int j = 1; j < 16; j++) begin
      if (done) begin
        gap = j;
        break;
      end
      if (j == 6) chk("b2b_hold", {hund, tens, ones}, 12'h042);
      @(negedge clk);
    end
    chk("b2b_gap", gap, 11);
    chk("b2b_dig", {hund, tens, ones}, 12'h860);
    prev_res = 12'h860;

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd765;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_dig", {hund, tens, ones}, 12'h000);
    chk("abort_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    prev_res = 12'h000;
    run_conv("c1", 10'd1, 12'h001, 1'b0);

`ifdef BIN2BCD_RANGE_CHK_EN
    run_conv("oor1023", 10'd1023, 12'h999, 1'b1);
    run_conv("c5", 10'd5, 12'h005, 1'b0);
`else
    run_conv("oor1023", 10'd1023, 12'h023, 1'b0);
    run_conv("c1000", 10'd1000, 12'h000, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
